// File: rtl/debounce_bank.sv
// debounce_bank: a bank of N_CH button debouncers that run fully in parallel.
// Each channel passes its raw button level through a 2-flop synchronizer. A
// 4-state FSM then accepts a new level only after the level has been stable
// for DB_CYCLES clocks.
//
// Optional long-press detection is enabled by the macro DEBOUNCE_LONGPRESS_EN.
// When the macro is undefined, long_press is tied to 0 and no long-press
// counter logic is built.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   button_in   [N_CH] raw, bouncing button levels
//   db_level    [N_CH] debounced level, registered
//   rise_tick   [N_CH] one-cycle pulse when db_level goes 0->1
//   fall_tick   [N_CH] one-cycle pulse when db_level goes 1->0
//   long_press  [N_CH] high while the button is held past LONG_CYCLES

module debounce_lane #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic long_press
);
  localparam int MAXC = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // The raw input is asynchronous. Only sync1_q samples it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  logic lp_q, lp_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef DEBOUNCE_LONGPRESS_EN
    lp_d    = lp_q;
`endif
    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (sync2_q) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
`ifdef DEBOUNCE_LONGPRESS_EN
          // A release bounce drops long_press for good. The channel must be
          // held for another full LONG_CYCLES to raise it again.
          lp_d    = 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_LONGPRESS_EN
          // The counter saturates at LONG_LAST. long_press latches there.
          if (cnt_q == LONG_LAST) lp_d = 1'b1;
          else                    cnt_d = cnt_q + 1'b1;
`else
          cnt_d = '0;
`endif
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lp_q <= 1'b0;
    else       lp_q <= lp_d;
  end
  assign long_press = lp_q;
`else
  assign long_press = 1'b0;
`endif

  assign db_level  = db_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
endmodule

module debounce_bank #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] rise_tick,
  output logic [N_CH-1:0] fall_tick,
  output logic [N_CH-1:0] long_press
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_lane #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .button_in (button_in[i]),
      .db_level  (db_level[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i]),
      .long_press(long_press[i])
    );
  end
endmodule
